// File: rtl/mem_test_pkg.sv
// rtl/mem_test_pkg.sv - shared types for the BRAM sweep tester
package mem_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    PAT_FILL,
    PAT_ADDR,
    PAT_NADDR,
    PAT_CHECK
  } pat_t;

endpackage

// File: rtl/mem_pattern_gen.sv
// rtl/mem_pattern_gen.sv - combinational test pattern for one address
module mem_pattern_gen
  import mem_test_pkg::*;
#(
  parameter int WID_MEM = 2
) (
  input  logic [1:0]         pat_sel,
  input  logic [WID_MEM-1:0] fill,
  input  logic [31:0]        addr,
  output logic [WID_MEM-1:0] data
);

  // Only the low address bits feed the pattern; the rest are truncated away.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:WID_MEM];

  // Select the expected word for this address.
  always_comb begin
    data = fill;
    case (pat_t'(pat_sel))
      PAT_FILL:  data = fill;
      PAT_ADDR:  data = addr[WID_MEM-1:0];
      PAT_NADDR: data = ~addr[WID_MEM-1:0];
      PAT_CHECK: data = addr[0] ? ~fill : fill;
      default:   data = fill;
    endcase
  end

endmodule

// File: rtl/mem_sweep_tester.sv
// rtl/mem_sweep_tester.sv - write/verify sweep over a BRAM with error capture
module mem_sweep_tester
  import mem_test_pkg::*;
#(
  parameter int WID_MEM   = 2,
  parameter int DEPTH_MEM = 32768,
  parameter int PARK_ADDR = DEPTH_MEM - 1,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [1:0]         pat_sel,
  input  logic [WID_MEM-1:0] fill,
  output logic [31:0]        raddr,
  output logic [31:0]        waddr,
  output logic [WID_MEM-1:0] din,
  input  logic [WID_MEM-1:0] dout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   err_count,
  output logic [31:0]        first_err_addr,
  output logic [WID_MEM-1:0] first_err_data
);

  // Last swept address (N-1); the park word sits just above it.
  localparam logic [31:0] LAST = 32'(DEPTH_MEM - 2);
  localparam logic [31:0] PARK = 32'(PARK_ADDR);

  state_t             state, state_nxt;
  logic [31:0]        a, a_nxt;
  logic [WID_MEM-1:0] pat_nxt;

  logic [31:0]        raddr_d, waddr_d;
  logic [WID_MEM-1:0] din_d;
  logic               busy_d, done_d, rd_d;

  logic               rd_r;
  logic [WID_MEM-1:0] exp_r;
  logic               p_valid;
  logic [31:0]        p_addr;
  logic [WID_MEM-1:0] p_exp;
  logic               seen;
  logic               accept;
  logic               mism;

  assign accept = (state == IDLE) && start;
  assign mism   = p_valid && (dout != p_exp);

  // Pattern is evaluated on the next address so din and the expected word
  // can be registered in step with waddr/raddr.
  mem_pattern_gen #(.WID_MEM(WID_MEM)) u_pat (
    .pat_sel(pat_sel),
    .fill   (fill),
    .addr   (a_nxt),
    .data   (pat_nxt)
  );

  // State and sweep counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      a     <= '0;
    end else begin
      state <= state_nxt;
      a     <= a_nxt;
    end
  end

  // Next state and next address.
  always_comb begin
    state_nxt = state;
    a_nxt     = '0;
    case (state)
      IDLE:  if (start) state_nxt = mode ? WRITE : READ;
      WRITE: if (a == LAST) state_nxt = READ;  else a_nxt = a + 32'd1;
      READ:  if (a == LAST) state_nxt = DRAIN; else a_nxt = a + 32'd1;
      DRAIN: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output values for the coming cycle; writes go to the park word unless writing.
  always_comb begin
    raddr_d = '0;
    waddr_d = PARK;
    din_d   = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rd_d    = 1'b0;
    case (state_nxt)
      WRITE: begin
        waddr_d = a_nxt;
        din_d   = pat_nxt;
        busy_d  = 1'b1;
      end
      READ: begin
        raddr_d = a_nxt;
        rd_d    = 1'b1;
        busy_d  = 1'b1;
      end
      DRAIN:   busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  // Registered memory-side outputs and the compare pipeline that tracks dout latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raddr   <= '0;
      waddr   <= PARK;
      din     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_r    <= 1'b0;
      exp_r   <= '0;
      p_valid <= 1'b0;
      p_addr  <= '0;
      p_exp   <= '0;
    end else begin
      raddr   <= raddr_d;
      waddr   <= waddr_d;
      din     <= din_d;
      busy    <= busy_d;
      done    <= done_d;
      rd_r    <= rd_d;
      exp_r   <= pat_nxt;
      p_valid <= rd_r;
      p_addr  <= raddr;
      p_exp   <= exp_r;
    end
  end

  // Error accounting; pass is decided in DRAIN so it is valid alongside done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      pass           <= 1'b0;
      seen           <= 1'b0;
    end else if (accept) begin
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      pass           <= 1'b0;
      seen           <= 1'b0;
    end else begin
      if (mism) begin
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
        if (!seen) begin
          seen           <= 1'b1;
          first_err_addr <= p_addr;
          first_err_data <= dout;
        end
      end
      if (state == DRAIN) pass <= (err_count == '0) && !mism;
    end
  end

endmodule

// File: tb/tb_mem_sweep_tester.sv
// tb/tb_mem_sweep_tester.sv - self-checking bench for mem_sweep_tester
module tb_mem_sweep_tester;

  localparam int W  = 2;
  localparam int D  = 16;
  localparam int N  = D - 1;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset, start, mode;
  logic [1:0]    pat_sel, fill;
  logic [31:0]   raddr, waddr;
  logic [W-1:0]  din, dout;
  logic          busy, done, pass;
  logic [CW-1:0] err_count;
  logic [31:0]   first_err_addr;
  logic [W-1:0]  first_err_data;

  always #5 clk = ~clk;

  mem_sweep_tester #(.WID_MEM(W), .DEPTH_MEM(D), .PARK_ADDR(D - 1), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .mode          (mode),
    .pat_sel       (pat_sel),
    .fill          (fill),
    .raddr         (raddr),
    .waddr         (waddr),
    .din           (din),
    .dout          (dout),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_addr(first_err_addr),
    .first_err_data(first_err_data)
  );

  // Memory model: write every clock, registered read, optional read corruption.
  logic [W-1:0] mem      [0:D-1];
  logic [W-1:0] init_mem [0:D-1];
  logic         load_en;
  logic         corrupt_en;
  int           corrupt_addr;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < D; i++) mem[i] <= init_mem[i];
    end else begin
      mem[waddr[3:0]] <= din;
    end
    dout <= (corrupt_en && raddr == 32'(corrupt_addr)) ? 2'b11 : mem[raddr[3:0]];
  end

  int total  = 0;
  int passed = 0;

  int           busy_cycles, done_cnt, park_bad, timed_out;
  int           wa_q[$];
  logic [1:0]   wd_q[$];
  logic         res_pass;
  logic [CW-1:0] res_err;
  logic [31:0]  res_fa;
  logic [1:0]   res_fd;

  function automatic logic [1:0] ref_pat(input int ps, input logic [1:0] f, input int k);
    case (ps)
      0:       return f;
      1:       return 2'(k % 4);
      2:       return 2'(3 - (k % 4));
      default: return (k % 2 == 1) ? 2'(3 - int'(f)) : f;
    endcase
  endfunction

  task automatic load_mem;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Pulses start, records the sweep until done, then samples results one cycle later.
  task automatic sweep(input logic m, input logic [1:0] ps, input logic [1:0] f, input int restart_at);
    mode = m; pat_sel = ps; fill = f;
    busy_cycles = 0; done_cnt = 0; park_bad = 0; timed_out = 1;
    wa_q.delete(); wd_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (busy) busy_cycles++;
      if (waddr != 32'(D - 1)) begin
        wa_q.push_back(int'(waddr));
        wd_q.push_back(din);
      end else if (din != 2'b00) park_bad++;
      if (done) begin
        done_cnt++;
        timed_out = 0;
        break;
      end
      start = (c == restart_at);
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    res_pass = pass; res_err = err_count; res_fa = first_err_addr; res_fd = first_err_data;
  endtask

  task automatic test_reset;
    logic [105:0] act, exp;
    exp = {32'd0, 32'd15, 2'd0, 3'b000, 3'd0, 32'd0, 2'd0};
    repeat (3) @(negedge clk);
    act = {raddr, waddr, din, busy, done, pass, err_count, first_err_addr, first_err_data};
    total++;
    if (act !== exp) $display("FAIL reset_held got=%h exp=%h", act, exp); else passed++;
    reset = 1'b1;
    @(negedge clk);
    act = {raddr, waddr, din, busy, done, pass, err_count, first_err_addr, first_err_data};
    total++;
    if (act !== exp) $display("FAIL reset_idle got=%h exp=%h", act, exp); else passed++;
  endtask

  task automatic test_write_verify;
    int seq_bad;
    for (int k = 0; k < D; k++) init_mem[k] = 2'b00;
    init_mem[D - 1] = 2'b11;
    corrupt_en = 1'b0;
    load_mem();
    sweep(1'b1, 2'd1, 2'd0, -1);
    seq_bad = 0;
    for (int i = 0; i < wa_q.size(); i++)
      if (wa_q[i] != i || wd_q[i] != 2'(i % 4)) seq_bad++;
    total++;
    if (timed_out != 0) $display("FAIL wv_timeout got=%0d exp=0", timed_out); else passed++;
    total++;
    if (busy_cycles != 2 * N + 1) $display("FAIL wv_busy got=%0d exp=%0d", busy_cycles, 2 * N + 1); else passed++;
    total++;
    if (wa_q.size() != N || seq_bad != 0) $display("FAIL wv_writes got=%0d/%0d exp=%0d/0", wa_q.size(), seq_bad, N); else passed++;
    total++;
    if (park_bad != 0 || mem[D - 1] !== 2'b00) $display("FAIL wv_park got=%0d/%b exp=0/00", park_bad, mem[D - 1]); else passed++;
    total++;
    if (res_pass !== 1'b1 || res_err !== 3'd0) $display("FAIL wv_result got=%b/%0d exp=1/0", res_pass, res_err); else passed++;
  endtask

  task automatic test_corrupt_read;
    corrupt_en = 1'b1; corrupt_addr = 5;
    sweep(1'b1, 2'd1, 2'd0, -1);
    corrupt_en = 1'b0;
    total++;
    if (res_err !== 3'd1 || res_fa !== 32'd5 || res_fd !== 2'b11 || res_pass !== 1'b0)
      $display("FAIL corrupt got=%0d/%0d/%b/%b exp=1/5/11/0", res_err, res_fa, res_fd, res_pass);
    else passed++;
  endtask

  task automatic test_verify_only;
    for (int k = 0; k < D; k++) init_mem[k] = 2'b10;
    init_mem[3] = 2'b01;
    init_mem[9] = 2'b00;
    load_mem();
    sweep(1'b0, 2'd0, 2'b10, -1);
    total++;
    if (busy_cycles != N + 1) $display("FAIL vo_busy got=%0d exp=%0d", busy_cycles, N + 1); else passed++;
    total++;
    if (wa_q.size() != 0 || park_bad != 0) $display("FAIL vo_park got=%0d/%0d exp=0/0", wa_q.size(), park_bad); else passed++;
    total++;
    if (res_err !== 3'd2 || res_fa !== 32'd3 || res_fd !== 2'b01 || res_pass !== 1'b0)
      $display("FAIL vo_result got=%0d/%0d/%b/%b exp=2/3/01/0", res_err, res_fa, res_fd, res_pass);
    else passed++;
  endtask

  task automatic test_saturate;
    for (int k = 0; k < D; k++) init_mem[k] = 2'b10;
    load_mem();
    sweep(1'b0, 2'd3, 2'b00, -1);
    total++;
    if (res_err !== 3'd7 || res_fa !== 32'd0 || res_fd !== 2'b10 || res_pass !== 1'b0)
      $display("FAIL saturate got=%0d/%0d/%b/%b exp=7/0/10/0", res_err, res_fa, res_fd, res_pass);
    else passed++;
  endtask

  task automatic test_reset_mid;
    logic [105:0] act, exp;
    int hit, extra;
    exp = {32'd0, 32'd15, 2'd0, 3'b000, 3'd0, 32'd0, 2'd0};
    mode = 1'b1; pat_sel = 2'd1; fill = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int c = 0; c < 100; c++) begin
      if (busy && raddr == 32'd7) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (hit != 1) $display("FAIL mid_reach_read7 got=%0d exp=1", hit); else passed++;
    reset = 1'b0;
    #1;
    act = {raddr, waddr, din, busy, done, pass, err_count, first_err_addr, first_err_data};
    total++;
    if (act !== exp) $display("FAIL mid_async got=%h exp=%h", act, exp); else passed++;
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) extra++;
    end
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    total++;
    if (extra != 0) $display("FAIL mid_no_done got=%0d exp=0", extra); else passed++;
    sweep(1'b1, 2'd1, 2'd0, -1);
    total++;
    if (busy_cycles != 2 * N + 1 || res_pass !== 1'b1 || res_err !== 3'd0)
      $display("FAIL mid_rerun got=%0d/%b/%0d exp=31/1/0", busy_cycles, res_pass, res_err);
    else passed++;
  endtask

  task automatic test_start_ignored;
    int extra;
    sweep(1'b1, 2'd1, 2'd0, 3);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    total++;
    if (busy_cycles != 2 * N + 1 || done_cnt != 1 || extra != 0)
      $display("FAIL restart_ignored got=%0d/%0d/%0d exp=31/1/0", busy_cycles, done_cnt, extra);
    else passed++;
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      logic       m;
      logic [1:0] ps, f, ex, ac, fd;
      int         errs, fa, sat;
      m  = 1'($urandom % 2);
      ps = 2'($urandom % 4);
      f  = 2'($urandom % 4);
      for (int k = 0; k < D; k++) init_mem[k] = 2'($urandom % 4);
      corrupt_en   = 1'($urandom % 2);
      corrupt_addr = $urandom_range(0, N - 1);
      load_mem();
      errs = 0; fa = 0; fd = 2'b00;
      for (int k = 0; k < N; k++) begin
        ex = ref_pat(int'(ps), f, k);
        ac = m ? ex : init_mem[k];
        if (corrupt_en && k == corrupt_addr) ac = 2'b11;
        if (ac != ex) begin
          if (errs == 0) begin
            fa = k;
            fd = ac;
          end
          errs++;
        end
      end
      sat = (errs > 7) ? 7 : errs;
      sweep(m, ps, f, -1);
      corrupt_en = 1'b0;
      total++;
      if (busy_cycles != (m ? 2 * N + 1 : N + 1))
        $display("FAIL rnd%0d_busy got=%0d exp=%0d", it, busy_cycles, m ? 2 * N + 1 : N + 1);
      else passed++;
      total++;
      if (res_err !== 3'(sat) || res_pass !== (errs == 0))
        $display("FAIL rnd%0d_count got=%0d/%b exp=%0d/%b", it, res_err, res_pass, sat, errs == 0);
      else passed++;
      if (errs > 0) begin
        total++;
        if (res_fa !== 32'(fa) || res_fd !== fd)
          $display("FAIL rnd%0d_first got=%0d/%b exp=%0d/%b", it, res_fa, res_fd, fa, fd);
        else passed++;
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0; pat_sel = 2'd0; fill = 2'd0;
    load_en = 1'b0; corrupt_en = 1'b0; corrupt_addr = 0;
    for (int k = 0; k < D; k++) init_mem[k] = 2'b00;
    test_reset();
    test_write_verify();
    test_corrupt_read();
    test_verify_only();
    test_saturate();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
